// File: rtl/fadd_arbiter_pkg.sv
// Shared types and helpers for the fadd arbiter slice.
package fadd_arb_pkg;

    localparam int FP_SIGN = 31;
    localparam int ID_MAXW = 3;

    typedef struct packed {
        logic [ID_MAXW-1:0] id;
        logic [31:0]        y;
        logic               ovf;
    } rsp_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fadd_arbiter_if.sv
// Requester and response handshake bundle between core issue logic and the fadd arbiter.
interface fadd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_x1;
    logic [NREQ*32-1:0] req_x2;
    logic [NREQ-1:0]    req_sub;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_y;
    logic               rsp_ovf;

    modport master (
        output req_valid, req_x1, req_x2, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf
    );
endinterface

// File: rtl/fadd_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: ptr_nxt only advances past the winner when en is high.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic [IDW-1:0]  ptr_nxt
);
    logic           found;
    logic [IDW-1:0] j;

    // With no request the index rests on ptr so idle operands stay deterministic.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        j         = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = j;
            end
        end
    end

    assign ptr_nxt = !en ? ptr :
                     (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined fadd among NREQ requesters with round-robin issue and an in-order response FIFO.
// Latency: result visible on rsp_valid LAT+1 cycles after the request handshake.
// Backpressure: issue stalls once RSPQ ops are outstanding; rsp_ready pops the FIFO head.
module fadd_arbiter
    import fadd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 1,
    parameter int RSPQ = 4
) (
    input  logic           clk,
    input  logic           rstn,
    fadd_arbiter_if.slave  bus,
    output logic [31:0]    fadd_x1,
    output logic [31:0]    fadd_x2,
    input  logic [31:0]    fadd_y,
    input  logic           fadd_ovf,
    output logic           busy
);
    localparam int PW = clog2(RSPQ);
    localparam int CW = clog2(RSPQ + 1);

    logic [IDW-1:0]  ptr, ptr_nxt, grant_idx;
    logic [NREQ-1:0] grant;
    logic            can_issue, issue, push, pop;
    logic [CW-1:0]   out_cnt, fifo_cnt;
    logic [PW-1:0]   wptr, rptr;
    logic [31:0]     x1_arr [NREQ];
    logic [31:0]     x2_arr [NREQ];
    logic [31:0]     x2_sel;
    logic [LAT-1:0]  tag_vld;
    logic [IDW-1:0]  tag_id [LAT];
    rsp_t            mem [RSPQ];
    rsp_t            head, push_dat;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(RSPQ-1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign x1_arr[i] = bus.req_x1[32*i +: 32];
        assign x2_arr[i] = bus.req_x2[32*i +: 32];
    end

    // No same-cycle pop credit: a full outstanding count blocks issue even while popping.
    assign can_issue = (out_cnt < CW'(RSPQ));
    assign issue     = can_issue & (|bus.req_valid);

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .en        (issue),
        .grant     (grant),
        .grant_idx (grant_idx),
        .ptr_nxt   (ptr_nxt)
    );

    assign bus.req_ready = issue ? grant : '0;
    assign fadd_x1       = x1_arr[grant_idx];
    assign x2_sel        = x2_arr[grant_idx];
    assign fadd_x2       = {x2_sel[FP_SIGN] ^ bus.req_sub[grant_idx], x2_sel[FP_SIGN-1:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr     <= '0;
            tag_vld <= '0;
        end else begin
            ptr        <= ptr_nxt;
            tag_vld[0] <= issue;
            for (int s = 1; s < LAT; s++) tag_vld[s] <= tag_vld[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= grant_idx;
        for (int s = 1; s < LAT; s++) tag_id[s] <= tag_id[s-1];
    end

    assign push          = tag_vld[LAT-1];
    assign bus.rsp_valid = (fifo_cnt != '0);
    assign pop           = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        push_dat     = '0;
        push_dat.id  = ID_MAXW'(tag_id[LAT-1]);
        push_dat.y   = fadd_y;
        push_dat.ovf = fadd_ovf;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            if (push) wptr <= wrap_inc(wptr);
            if (pop)  rptr <= wrap_inc(rptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({issue, pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign head = mem[rptr];

    // Response fields read as zero whenever the FIFO is empty.
    always_comb begin
        bus.rsp_id  = '0;
        bus.rsp_y   = '0;
        bus.rsp_ovf = 1'b0;
        if (bus.rsp_valid) begin
            bus.rsp_id  = IDW'(head.id);
            bus.rsp_y   = head.y;
            bus.rsp_ovf = head.ovf;
        end
    end

    assign busy = (out_cnt != '0);

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter with a one-cycle table-driven fadd stand-in.
module tb_fadd_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] fadd_x1, fadd_x2, fadd_y;
    logic        fadd_ovf, busy;
    logic [31:0] x1v [4];
    logic [31:0] x2v [4];
    logic [31:0] yexp [4];
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    fadd_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

    assign bus.req_x1 = {x1v[3], x1v[2], x1v[1], x1v[0]};
    assign bus.req_x2 = {x2v[3], x2v[2], x2v[1], x2v[0]};

    fadd_arbiter #(.NREQ(4), .IDW(2), .LAT(1), .RSPQ(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .fadd_x1  (fadd_x1),
        .fadd_x2  (fadd_x2),
        .fadd_y   (fadd_y),
        .fadd_ovf (fadd_ovf),
        .busy     (busy)
    );

    // Hand-computed FP32 sums for every operand pair the bench issues.
    function automatic logic [32:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return {1'b0, 32'h40400000};
            64'h40400000_BF800000: return {1'b0, 32'h40000000};
            64'h3F800000_3F800000: return {1'b0, 32'h40000000};
            64'h40000000_40000000: return {1'b0, 32'h40800000};
            64'h40400000_40400000: return {1'b0, 32'h40C00000};
            64'h40800000_40800000: return {1'b0, 32'h41000000};
            64'h7F7FFFFF_7F7FFFFF: return {1'b1, 32'h7F800000};
            default:               return {1'b0, 32'hDEADBEEF};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            fadd_y   <= '0;
            fadd_ovf <= 1'b0;
        end else begin
            {fadd_ovf, fadd_y} <= fadd_ref(fadd_x1, fadd_x2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            step();
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x1v[i] = '0;
            x2v[i] = '0;
        end
        yexp[0] = 32'h40000000;
        yexp[1] = 32'h40800000;
        yexp[2] = 32'h40C00000;
        yexp[3] = 32'h41000000;

        // Reset state
        rstn = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_vld",  32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy),          32'd0);
        chk("rst_id",   32'(bus.rsp_id),    32'd0);
        chk("rst_y",    bus.rsp_y,          32'd0);
        chk("rst_ovf",  32'(bus.rsp_ovf),   32'd0);
        step();
        rstn = 1'b1;
        bus.rsp_ready = 1'b1;

        // Single add on requester 0: 1.0 + 2.0
        x1v[0] = 32'h3F800000;
        x2v[0] = 32'h40000000;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_rdy", 32'(bus.req_ready), 32'h1);
        chk("t1_x1",  fadd_x1, 32'h3F800000);
        chk("t1_x2",  fadd_x2, 32'h40000000);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("t1_busy",  32'(busy),          32'd1);
        chk("t1_early", 32'(bus.rsp_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1_vld", 32'(bus.rsp_valid), 32'd1);
        chk("t1_id",  32'(bus.rsp_id),    32'd0);
        chk("t1_y",   bus.rsp_y,          32'h40400000);
        chk("t1_ovf", 32'(bus.rsp_ovf),   32'd0);
        step();
        @(negedge clk);
        chk("t1_empty", 32'(bus.rsp_valid), 32'd0);
        chk("t1_idle",  32'(busy),          32'd0);

        // Subtract on requester 1: 3.0 - 1.0
        x1v[1] = 32'h40400000;
        x2v[1] = 32'h3F800000;
        bus.req_sub   = 4'b0010;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("t2_rdy", 32'(bus.req_ready), 32'h2);
        chk("t2_x2",  fadd_x2, 32'hBF800000);
        step();
        bus.req_valid = '0;
        bus.req_sub   = '0;
        step();
        @(negedge clk);
        chk("t2_vld", 32'(bus.rsp_valid), 32'd1);
        chk("t2_id",  32'(bus.rsp_id),    32'd1);
        chk("t2_y",   bus.rsp_y,          32'h40000000);
        step();

        // All four valid, consumer always ready
        do_reset();
        x1v[0] = 32'h3F800000; x2v[0] = 32'h3F800000;
        x1v[1] = 32'h40000000; x2v[1] = 32'h40000000;
        x1v[2] = 32'h40400000; x2v[2] = 32'h40400000;
        x1v[3] = 32'h40800000; x2v[3] = 32'h40800000;
        bus.req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) bus.req_valid = '0;
            @(negedge clk);
            if (c < 8) chk("t3_rdy", 32'(bus.req_ready), 32'(1 << (c % 4)));
            else       chk("t3_rdy", 32'(bus.req_ready), 32'd0);
            if (c >= 2) begin
                chk("t3_vld", 32'(bus.rsp_valid), 32'd1);
                chk("t3_id",  32'(bus.rsp_id),    32'((c - 2) % 4));
                chk("t3_y",   bus.rsp_y,          yexp[(c - 2) % 4]);
            end
            step();
        end
        wait_idle("t3_drain");

        // Consumer stalled: only RSPQ issues, then ordered drain and resumed issue
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t4_rdy", 32'(bus.req_ready), (c < 4) ? 32'(1 << c) : 32'd0);
            if (c >= 4) begin
                chk("t4_hvld", 32'(bus.rsp_valid), 32'd1);
                chk("t4_hid",  32'(bus.rsp_id),    32'd0);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        begin
            logic [3:0] rdy_tab [5];
            logic [1:0] id_tab  [5];
            rdy_tab[0] = 4'h0; rdy_tab[1] = 4'h1; rdy_tab[2] = 4'h2; rdy_tab[3] = 4'h4; rdy_tab[4] = 4'h8;
            id_tab[0]  = 2'd0; id_tab[1]  = 2'd1; id_tab[2]  = 2'd2; id_tab[3]  = 2'd3; id_tab[4]  = 2'd0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("t4_rdy2", 32'(bus.req_ready), 32'(rdy_tab[c]));
                chk("t4_id",   32'(bus.rsp_id),    32'(id_tab[c]));
                chk("t4_y",    bus.rsp_y,          yexp[id_tab[c]]);
                step();
            end
        end
        bus.req_valid = '0;
        wait_idle("t4_drain");

        // Overflow on requester 2
        x1v[2] = 32'h7F7FFFFF;
        x2v[2] = 32'h7F7FFFFF;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("t5_rdy", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        chk("t5_vld", 32'(bus.rsp_valid), 32'd1);
        chk("t5_id",  32'(bus.rsp_id),    32'd2);
        chk("t5_y",   bus.rsp_y,          32'h7F800000);
        chk("t5_ovf", 32'(bus.rsp_ovf),   32'd1);
        step();

        // Reset with two ops in flight
        bus.rsp_ready = 1'b0;
        x1v[0] = 32'h3F800000;
        x2v[0] = 32'h40000000;
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = '0;
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        chk("t6_vld", 32'(bus.rsp_valid), 32'd0);
        chk("t6_busy", 32'(busy),         32'd0);
        step();
        rstn = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t6_stale_vld",  32'(bus.rsp_valid), 32'd0);
            chk("t6_stale_busy", 32'(busy),          32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fadd_arbiter.md
Name: fadd_arbiter

Overview:
Shares one pipelined fadd instance among NREQ requesters. Each requester has a valid/ready handshake and may ask for add or subtract. The block picks one requester per cycle by round-robin and drives the fadd operands. It tracks in-flight operations with a tag pipeline matched to the fadd latency, and buffers results in a small response FIFO that has rsp_valid/rsp_ready backpressure. It sits between the FPU-issuing core logic and the fadd datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester id width, equal to clog2(NREQ)
LAT, 1, fadd latency in cycles from operand edge to y valid; must equal the fadd's NSTAGE
RSPQ, 4, response FIFO depth; must be at least LAT+1

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  NREQ  request valid per requester
req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
req_x1  in  NREQ*32  operand 1 per requester; slice i is [32i+31:32i]
req_x2  in  NREQ*32  operand 2 per requester
req_sub  in  NREQ  1 means x1-x2, 0 means x1+x2
fadd_x1  out  32  operand to fadd
fadd_x2  out  32  operand to fadd (sign-adjusted)
fadd_y  in  32  fadd result
fadd_ovf  in  1  fadd overflow flag
rsp_valid  out  1  response available at FIFO head
rsp_ready  in  1  consumer takes response
rsp_id  out  IDW  requester id of head response
rsp_y  out  32  result
rsp_ovf  out  1  overflow flag
busy  out  1  at least one operation in flight or buffered

Behaviour:
- Clock and reset: clk; rstn is synchronous and active-low. The fadd instance is reset by the same rstn.
- Reset state:
  - rr pointer = 0; tag pipeline valids = 0.
  - FIFO empty, so rsp_valid = 0.
  - outstanding counter = 0, so busy = 0.
  - rsp_id, rsp_y and rsp_ovf are 0 while the FIFO is empty.
- Reset mid-operation: all in-flight and buffered results are discarded; nothing is emitted after reset.
- Outstanding counter: 0..RSPQ, counting operations issued but not yet popped.
  - Increments on issue, decrements on pop (rsp_valid & rsp_ready).
  - Issue and pop in the same cycle leave it unchanged.
  - busy = (outstanding != 0).
- Issue rule, combinational each cycle:
  - can_issue = (outstanding < RSPQ). There is no same-cycle pop credit.
  - Grant goes to the first i with req_valid[i], searching from ptr upward and wrapping modulo NREQ.
  - issue = can_issue & any valid.
  - req_ready[i] = grant[i] & issue.
  - req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: on issue, ptr <= (granted index + 1) mod NREQ. With no issue, ptr is held.
- Operand drive:
  - fadd_x1 = req_x1 of the granted requester.
  - fadd_x2 = req_x2 of the granted requester, with bit 31 inverted when req_sub is set. This also flips the sign of NaN inputs, which is accepted.
  - When there is no issue, the operands are don't-care but deterministic (driven from the ptr slot); the fadd result for that cycle is ignored.
- Tag pipeline:
  - LAT-deep shift register of {valid, id}; stage 0 is loaded with {issue, granted id} at the clock edge.
  - While the last stage is valid, fadd_y is valid, and {id, fadd_y, fadd_ovf} is pushed into the FIFO at that edge.
- Timing for a handshake in cycle k:
  - fadd_y is valid in cycle k+LAT.
  - The result is pushed at the end of that cycle.
  - rsp_valid is high from cycle k+LAT+1; there is no FIFO bypass.
- FIFO behaviour:
  - First-word fall-through, RSPQ entries, wrap-around read and write pointers.
  - Push and pop in the same cycle are allowed, including when full or empty.
  - The outstanding counter guarantees that a push never hits a full FIFO.
- Ordering: responses leave in issue order; ids identify the owner.
- Throughput: one op per cycle sustained when rsp_ready is held at 1 and RSPQ >= LAT+2.

Decomposition:
- Package fadd_arb_pkg holds:
  - an FP32 field-position constant for the sign bit (31);
  - a response struct typedef {id, y, ovf};
  - a clog2 helper function.
- Sub-module rr_arbiter (NREQ): inputs req, ptr and en; outputs grant (one-hot) and grant_idx, and computes the ptr update.
- The FIFO and tag pipeline stay inline.

Test Plan:
- Req0 add x1=0x3F800000, x2=0x40000000, rsp_ready=1 → req_ready[0] in cycle 0; rsp_valid in cycle LAT+1 with id=0, y=0x40400000, ovf=0; busy drops the next cycle.
- Req1 sub x1=0x40400000, x2=0x3F800000 → rsp y=0x40000000, id=1.
- All four requesters valid continuously → grants 0,1,2,3,0,…, one per cycle; responses in the same id order.
- rsp_ready=0 with all valid → exactly RSPQ issues, then req_ready=0; rsp_ready=1 afterwards drains in order and issue resumes.
- Req2 add 0x7F7FFFFF + 0x7F7FFFFF → y=0x7F800000, ovf=1, id=2.
- rstn=0 asserted while 2 ops are in flight → next cycle rsp_valid=0, busy=0; no stale response appears after rstn=1.
